icache_refill_controller: RTL and testbench

- Parametrised next-generation instruction-cache controller between the fetch stage, the I-cache data/tag array and instruction memory.
- Block size, word size, address width and memory bus width are configurable.
- Memory refills a block in multiple beats, critical beat first with wrap-around.
- Early restart: the fetch stage is released as soon as the requested word arrives. The rest of the block streams into a fill buffer and is then written to the cache.

---
 rtl/icache_refill_controller_if.sv | 44 ++++
 rtl/icache_refill_controller.sv | 172 +++++++++++++++++
 tb/tb_icache_refill_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_controller_if.sv
// Fetch / cache-array / instruction-memory signal bundle for the I-cache
// refill controller. The master modport is the controller side; the slave
// modport is the environment (fetch stage, cache arrays, memory).
interface icache_refill_controller_if #(
    parameter int ADDR_SIZE       = 8,
    parameter int WORD_BITS       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BEAT_BITS       = 32
);
    localparam int BLOCK_BITS = WORD_BITS * WORDS_PER_BLOCK;
    localparam int BEATS      = BLOCK_BITS / BEAT_BITS;
    localparam int OFFS       = $clog2(BLOCK_BITS / 8);
    localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // fetch stage
    logic                       ren;
    logic [ADDR_SIZE-1:0]       addr;
    logic                       stall;
    logic [WORD_BITS-1:0]       dout;
    // cache arrays
    logic [ADDR_SIZE-OFFS-1:0]  BlockAddr;
    logic                       cacheRen;
    logic                       cacheHit;
    logic [BLOCK_BITS-1:0]      cacheDout;
    logic                       cacheMemWen;
    logic [BLOCK_BITS-1:0]      cacheDin;
    // instruction memory
    logic                       memRen;
    logic [BEAT_IDX_W-1:0]      memBeat;
    logic                       memReadReady;
    logic [BEAT_BITS-1:0]       memDout;

    modport master (
        input  ren, addr, cacheHit, cacheDout, memReadReady, memDout,
        output stall, dout, BlockAddr, cacheRen, cacheMemWen, cacheDin,
               memRen, memBeat
    );

    modport slave (
        output ren, addr, cacheHit, cacheDout, memReadReady, memDout,
        input  stall, dout, BlockAddr, cacheRen, cacheMemWen, cacheDin,
               memRen, memBeat
    );
endinterface

// File: rtl/icache_refill_controller.sv
// I-cache refill controller: zero-latency hits, critical-beat-first wrapped
// refills with early restart, and a one-cycle write of the completed block.
module icache_refill_controller #(
    parameter int ADDR_SIZE       = 8,
    parameter int WORD_BITS       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BEAT_BITS       = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    icache_refill_controller_if.master  bus
);
    localparam int BLOCK_BITS     = WORD_BITS * WORDS_PER_BLOCK;
    localparam int BEATS          = BLOCK_BITS / BEAT_BITS;
    localparam int OFFS           = $clog2(BLOCK_BITS / 8);
    localparam int BEAT_IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WOFF           = $clog2(WORD_BITS / 8);
    localparam int WORDS_PER_BEAT = BEAT_BITS / WORD_BITS;
    localparam int WORD_IDX_W     = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int CNT_W          = BEAT_IDX_W + 1;
    localparam int BLK_W          = ADDR_SIZE - OFFS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                 state_reg;
    logic [BLK_W-1:0]       blk_addr_reg;
    logic [WORD_IDX_W-1:0]  word_idx_reg;
    logic [BEAT_IDX_W-1:0]  crit_beat_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   restart_done_reg;
    logic [WORD_BITS-1:0]   dout_reg;

    logic [WORD_IDX_W-1:0]  req_word;
    logic [BEAT_IDX_W-1:0]  req_beat;
    logic [WORD_BITS-1:0]   hit_word;
    logic [WORD_BITS-1:0]   mem_word;
    logic [BEAT_IDX_W-1:0]  mem_beat;
    logic                   beat_fire;
    logic                   first_beat;
    logic                   last_beat;
    logic                   stall_next;
    logic                   cache_ren_next;
    logic [WORD_BITS-1:0]   dout_next;
    logic                   unused_addr_bits;

    // Word index within the block; byte-lane bits of the address are ignored.
    generate
        if (WORDS_PER_BLOCK > 1) begin : g_word_idx
            assign req_word = bus.addr[WOFF +: WORD_IDX_W];
        end else begin : g_word_idx_single
            assign req_word = '0;
        end
    endgenerate

    assign unused_addr_bits = ^bus.addr[WOFF-1:0];

    assign req_beat   = BEAT_IDX_W'(32'(req_word) / WORDS_PER_BEAT);
    assign hit_word   = bus.cacheDout[32'(req_word) * WORD_BITS +: WORD_BITS];
    // The requested word taken straight off the memory bus for early restart.
    assign mem_word   = bus.memDout[(32'(word_idx_reg) % WORDS_PER_BEAT) * WORD_BITS +: WORD_BITS];
    // Wrap-around beat order starting at the beat holding the requested word.
    assign mem_beat   = (state_reg == REFILL)
                      ? BEAT_IDX_W'((32'(crit_beat_reg) + 32'(count_reg)) % BEATS)
                      : '0;
    assign beat_fire  = (state_reg == REFILL) && bus.memReadReady;
    assign first_beat = beat_fire && !restart_done_reg;
    assign last_beat  = beat_fire && (count_reg == CNT_W'(BEATS - 1));

    // Fetch-facing responses: hits and early restart are visible in the same cycle.
    always_comb begin
        stall_next     = 1'b0;
        cache_ren_next = 1'b0;
        dout_next      = dout_reg;
        case (state_reg)
            IDLE: begin
                cache_ren_next = bus.ren;
                stall_next     = bus.ren && !bus.cacheHit;
                if (bus.ren && bus.cacheHit) begin
                    dout_next = hit_word;
                end
            end
            REFILL: begin
                if (first_beat) begin
                    stall_next = 1'b0;
                    dout_next  = mem_word;
                end else begin
                    stall_next = bus.ren;
                end
            end
            WRITE: begin
                stall_next = bus.ren;
            end
            default: begin
                stall_next = 1'b0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign bus.stall       = reset & stall_next;
    assign bus.dout        = reset ? dout_next : '0;
    assign bus.cacheRen    = reset & cache_ren_next;
    assign bus.BlockAddr   = (state_reg == IDLE) ? bus.addr[ADDR_SIZE-1:OFFS] : blk_addr_reg;
    assign bus.cacheMemWen = (state_reg == WRITE);
    assign bus.memRen      = (state_reg == REFILL);
    assign bus.memBeat     = mem_beat;

    // Refill FSM: miss capture, beat counting, early-restart bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg        <= IDLE;
            blk_addr_reg     <= '0;
            word_idx_reg     <= '0;
            crit_beat_reg    <= '0;
            count_reg        <= '0;
            restart_done_reg <= 1'b0;
            dout_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ren && bus.cacheHit) begin
                        dout_reg <= hit_word;
                    end else if (bus.ren) begin
                        blk_addr_reg     <= bus.addr[ADDR_SIZE-1:OFFS];
                        word_idx_reg     <= req_word;
                        crit_beat_reg    <= req_beat;
                        count_reg        <= '0;
                        restart_done_reg <= 1'b0;
                        state_reg        <= REFILL;
                    end
                end
                REFILL: begin
                    if (beat_fire) begin
                        count_reg <= count_reg + 1'b1;
                        if (first_beat) begin
                            restart_done_reg <= 1'b1;
                            dout_reg         <= mem_word;
                        end
                        if (last_beat) begin
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Fill buffer: one slot per memory beat, written in whatever order beats arrive.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_fill
            logic [BEAT_BITS-1:0] slot_reg;

            // Capture the beat addressed by memBeat when memory presents it.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else if (beat_fire && (mem_beat == BEAT_IDX_W'(gi))) begin
                    slot_reg <= bus.memDout;
                end
            end

            assign bus.cacheDin[gi*BEAT_BITS +: BEAT_BITS] = slot_reg;
        end
    endgenerate
endmodule

// File: tb/tb_icache_refill_controller.sv
// Self-checking bench for icache_refill_controller: default 4-beat build plus
// a single-beat (128-bit bus) build sharing clock and reset.
module tb_icache_refill_controller;
    logic clock;
    logic reset;

    int errors = 0;
    int checks = 0;

    logic [31:0]  exp_beat_q[$];
    logic [127:0] exp_blk_q[$];

    icache_refill_controller_if #(.ADDR_SIZE(8), .WORD_BITS(32), .WORDS_PER_BLOCK(4), .BEAT_BITS(32))  bus0();
    icache_refill_controller_if #(.ADDR_SIZE(8), .WORD_BITS(32), .WORDS_PER_BLOCK(4), .BEAT_BITS(128)) bus1();

    icache_refill_controller #(.ADDR_SIZE(8), .WORD_BITS(32), .WORDS_PER_BLOCK(4), .BEAT_BITS(32)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    icache_refill_controller #(.ADDR_SIZE(8), .WORD_BITS(32), .WORDS_PER_BLOCK(4), .BEAT_BITS(128)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus0.ren = 1'b0; bus0.addr = '0; bus0.cacheHit = 1'b0; bus0.cacheDout = '0;
        bus0.memReadReady = 1'b0; bus0.memDout = '0;
        bus1.ren = 1'b0; bus1.addr = '0; bus1.cacheHit = 1'b0; bus1.cacheDout = '0;
        bus1.memReadReady = 1'b0; bus1.memDout = '0;
    endtask

    task automatic test_reset();
        bus0.ren = 1'b1; bus0.addr = 8'h38; bus0.cacheHit = 1'b0;
        #2;
        checks++; if (bus0.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus0.stall); end
        checks++; if (bus0.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus0.dout); end
        checks++; if (bus0.memRen !== 1'b0) begin errors++; $display("FAIL reset_memRen got=%b exp=0", bus0.memRen); end
        checks++; if (bus0.cacheMemWen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", bus0.cacheMemWen); end
        checks++; if (bus0.memBeat !== 2'd0) begin errors++; $display("FAIL reset_memBeat got=%0d exp=0", bus0.memBeat); end
        checks++; if (bus0.cacheDin !== 128'h0) begin errors++; $display("FAIL reset_cacheDin got=%h exp=0", bus0.cacheDin); end
        bus0.ren = 1'b0; bus0.addr = '0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        $display("reset: checked outputs under reset");
    endtask

    task automatic test_hit();
        bus0.ren = 1'b1; bus0.addr = 8'h14; bus0.cacheHit = 1'b1;
        bus0.cacheDout = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
        @(negedge clock);
        checks++; if (bus0.stall !== 1'b0) begin errors++; $display("FAIL hit_stall got=%b exp=0", bus0.stall); end
        checks++; if (bus0.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_dout got=%h exp=deadbeef", bus0.dout); end
        checks++; if (bus0.BlockAddr !== 4'h1) begin errors++; $display("FAIL hit_blockaddr got=%h exp=1", bus0.BlockAddr); end
        checks++; if (bus0.cacheRen !== 1'b1) begin errors++; $display("FAIL hit_cacheRen got=%b exp=1", bus0.cacheRen); end
        checks++; if (bus0.memRen !== 1'b0 || bus0.cacheMemWen !== 1'b0) begin errors++; $display("FAIL hit_quiet got=%b%b exp=00", bus0.memRen, bus0.cacheMemWen); end
        next_cycle();
        bus0.ren = 1'b0; bus0.cacheHit = 1'b0; bus0.cacheDout = '0;
        @(negedge clock);
        checks++; if (bus0.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_dout_hold got=%h exp=deadbeef", bus0.dout); end
        checks++; if (bus0.stall !== 1'b0) begin errors++; $display("FAIL idle_stall got=%b exp=0", bus0.stall); end
        next_cycle();
        $display("hit: addr=14 dout=%h", 32'hDEADBEEF);
    endtask

    // Miss on dut0 at a, beats 0xA0+b, optional gap before arrival gap_at,
    // optional second request to 0x40 once early restart releases the pipe.
    task automatic run_miss(input logic [7:0] a, input int gap_at, input int gap_len, input bit b2b);
        logic [1:0]   crit;
        logic [127:0] blk;
        logic [31:0]  beat;
        logic         exp_ren;
        crit = a[3:2];
        blk  = '0;
        for (int b = 0; b < 4; b++) blk[b*32 +: 32] = 32'hA0 + 32'(b);
        exp_blk_q.push_back(blk);
        for (int k = 0; k < 4; k++) exp_beat_q.push_back(32'((32'(crit) + 32'(k)) % 4));
        exp_ren = 1'b1;
        bus0.ren = 1'b1; bus0.addr = a; bus0.cacheHit = 1'b0;
        @(negedge clock);
        checks++; if (bus0.stall !== 1'b1) begin errors++; $display("FAIL miss_stall got=%b exp=1", bus0.stall); end
        checks++; if (bus0.BlockAddr !== a[7:4]) begin errors++; $display("FAIL miss_blockaddr got=%h exp=%h", bus0.BlockAddr, a[7:4]); end
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus0.memReadReady = 1'b0; bus0.memDout = 32'hFFFFFFFF;
                    @(negedge clock);
                    checks++; if (32'(bus0.memBeat) !== exp_beat_q[0]) begin errors++; $display("FAIL gap_memBeat got=%0d exp=%0d", bus0.memBeat, exp_beat_q[0]); end
                    checks++; if (bus0.stall !== exp_ren || bus0.memRen !== 1'b1) begin errors++; $display("FAIL gap_stall_memRen got=%b%b exp=%b1", bus0.stall, bus0.memRen, exp_ren); end
                    next_cycle();
                end
            end
            beat = exp_beat_q.pop_front();
            bus0.memReadReady = 1'b1; bus0.memDout = 32'hA0 + beat;
            @(negedge clock);
            checks++; if (32'(bus0.memBeat) !== beat) begin errors++; $display("FAIL memBeat k=%0d got=%0d exp=%0d", k, bus0.memBeat, beat); end
            checks++; if (bus0.memRen !== 1'b1 || bus0.cacheRen !== 1'b0) begin errors++; $display("FAIL refill_ren k=%0d got=%b%b exp=10", k, bus0.memRen, bus0.cacheRen); end
            if (k == 0) begin
                checks++; if (bus0.stall !== 1'b0) begin errors++; $display("FAIL early_stall got=%b exp=0", bus0.stall); end
                checks++; if (bus0.dout !== 32'hA0 + 32'(crit)) begin errors++; $display("FAIL early_dout got=%h exp=%h", bus0.dout, 32'hA0 + 32'(crit)); end
            end else begin
                checks++; if (bus0.stall !== exp_ren) begin errors++; $display("FAIL refill_stall k=%0d got=%b exp=%b", k, bus0.stall, exp_ren); end
            end
            next_cycle();
            if (k == 0) begin
                exp_ren  = b2b;
                bus0.ren = b2b; bus0.addr = b2b ? 8'h40 : 8'h00;
            end
        end
        bus0.memReadReady = 1'b0; bus0.memDout = '0;
        @(negedge clock);
        blk = exp_blk_q.pop_front();
        checks++; if (bus0.cacheMemWen !== 1'b1) begin errors++; $display("FAIL write_wen got=%b exp=1", bus0.cacheMemWen); end
        checks++; if (bus0.cacheDin !== blk) begin errors++; $display("FAIL write_din got=%h exp=%h", bus0.cacheDin, blk); end
        checks++; if (bus0.BlockAddr !== a[7:4]) begin errors++; $display("FAIL write_blockaddr got=%h exp=%h", bus0.BlockAddr, a[7:4]); end
        checks++; if (bus0.memRen !== 1'b0 || bus0.stall !== exp_ren) begin errors++; $display("FAIL write_memRen_stall got=%b%b exp=0%b", bus0.memRen, bus0.stall, exp_ren); end
        next_cycle();
        if (b2b) begin
            bus0.cacheHit = 1'b1; bus0.cacheDout = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        end
        @(negedge clock);
        checks++; if (bus0.cacheMemWen !== 1'b0 || bus0.memRen !== 1'b0) begin errors++; $display("FAIL post_write got=%b%b exp=00", bus0.cacheMemWen, bus0.memRen); end
        if (b2b) begin
            checks++; if (bus0.cacheRen !== 1'b1 || bus0.BlockAddr !== 4'h4) begin errors++; $display("FAIL b2b_lookup got=%b/%h exp=1/4", bus0.cacheRen, bus0.BlockAddr); end
            checks++; if (bus0.stall !== 1'b0 || bus0.dout !== 32'hC0) begin errors++; $display("FAIL b2b_hit got=%b/%h exp=0/c0", bus0.stall, bus0.dout); end
        end
        next_cycle();
        bus0.ren = 1'b0; bus0.addr = '0; bus0.cacheHit = 1'b0; bus0.cacheDout = '0;
        next_cycle();
        $display("miss: addr=%h gap=%0d b2b=%0d block=%h", a, gap_len, b2b, blk);
    endtask

    task automatic test_miss_wrap();
        run_miss(8'h38, 9, 0, 1'b0);
    endtask

    task automatic test_gapped_beats();
        run_miss(8'h38, 2, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_miss(8'h38, 9, 0, 1'b1);
    endtask

    task automatic test_reset_mid_refill();
        bus0.ren = 1'b1; bus0.addr = 8'h38; bus0.cacheHit = 1'b0;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            bus0.memReadReady = 1'b1; bus0.memDout = 32'h55 + 32'(k);
            next_cycle();
        end
        reset = 1'b0;
        #1;
        checks++; if (bus0.memRen !== 1'b0) begin errors++; $display("FAIL rstmid_memRen got=%b exp=0", bus0.memRen); end
        checks++; if (bus0.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", bus0.stall); end
        checks++; if (bus0.memBeat !== 2'd0) begin errors++; $display("FAIL rstmid_memBeat got=%0d exp=0", bus0.memBeat); end
        next_cycle();
        reset = 1'b1;
        bus0.ren = 1'b0; bus0.addr = '0; bus0.memReadReady = 1'b1; bus0.memDout = 32'h77;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++; if (bus0.cacheMemWen !== 1'b0 || bus0.memRen !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite c=%0d got=%b%b exp=00", c, bus0.cacheMemWen, bus0.memRen); end
            next_cycle();
        end
        bus0.memReadReady = 1'b0; bus0.memDout = '0;
        $display("reset_mid_refill: refill abandoned");
        run_miss(8'h14, 9, 0, 1'b0);
    endtask

    task automatic test_single_beat();
        logic [127:0] blk;
        blk = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        exp_blk_q.push_back(blk);
        bus1.ren = 1'b1; bus1.addr = 8'h0C; bus1.cacheHit = 1'b0;
        @(negedge clock);
        checks++; if (bus1.stall !== 1'b1 || bus1.BlockAddr !== 4'h0) begin errors++; $display("FAIL b1_miss got=%b/%h exp=1/0", bus1.stall, bus1.BlockAddr); end
        next_cycle();
        bus1.memReadReady = 1'b1; bus1.memDout = blk;
        @(negedge clock);
        checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL b1_early_stall got=%b exp=0", bus1.stall); end
        checks++; if (bus1.dout !== 32'hB3) begin errors++; $display("FAIL b1_early_dout got=%h exp=b3", bus1.dout); end
        checks++; if (bus1.memRen !== 1'b1 || bus1.memBeat !== 1'b0) begin errors++; $display("FAIL b1_memRen_beat got=%b/%0d exp=1/0", bus1.memRen, bus1.memBeat); end
        next_cycle();
        bus1.memReadReady = 1'b0; bus1.memDout = '0; bus1.ren = 1'b0; bus1.addr = '0;
        @(negedge clock);
        blk = exp_blk_q.pop_front();
        checks++; if (bus1.cacheMemWen !== 1'b1) begin errors++; $display("FAIL b1_wen got=%b exp=1", bus1.cacheMemWen); end
        checks++; if (bus1.cacheDin !== blk) begin errors++; $display("FAIL b1_din got=%h exp=%h", bus1.cacheDin, blk); end
        next_cycle();
        @(negedge clock);
        checks++; if (bus1.cacheMemWen !== 1'b0) begin errors++; $display("FAIL b1_wen_once got=%b exp=0", bus1.cacheMemWen); end
        next_cycle();
        $display("single_beat: addr=0c block=%h", blk);
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        #1;
        reset = 1'b0;
        test_reset();
        test_hit();
        test_miss_wrap();
        test_gapped_beats();
        test_back_to_back();
        test_reset_mid_refill();
        test_single_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
